// File: rtl/bist_controller.sv
// BIST session sequencer: seeds the pattern generator, runs NUM_PATTERNS advances,
// compacts CUT responses into a MISR and compares the final signature to GOLDEN_SIG.
module bist_controller #(
  parameter int              WIDTH        = 8,
  parameter int              NUM_PATTERNS = 255,
  parameter int              CUT_LAT      = 1,
  parameter logic [WIDTH-1:0] MISR_SEED   = '0,
  parameter logic [WIDTH-1:0] MISR_TAPS   = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] GOLDEN_SIG  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             tpg_load,
  output logic             tpg_en,
  output logic             test_mode,
  input  logic [WIDTH-1:0] cut_resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      pattern_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_EVAL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   misr;
  logic [WIDTH-1:0]   misr_next;
  logic [CUT_LAT-1:0] vpipe;
  logic [CUT_LAT-1:0] pipe_next;
  logic               last_pat;
  logic               abort_hit;

  // Handshake: start and abort are level requests sampled on each rising edge;
  // start is accepted only in IDLE/DONE, abort in any state but IDLE and overrides start.
  assign abort_hit = abort && (state != S_IDLE);
  assign last_pat  = (pattern_cnt == 16'(NUM_PATTERNS - 1));
  assign pipe_next = CUT_LAT'({vpipe, tpg_en});
  assign misr_next = {misr[WIDTH-2:0], ^(misr & MISR_TAPS)} ^ cut_resp;
  assign signature = misr;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tpg_load   = 1'b0;
    tpg_en     = 1'b0;
    test_mode  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        tpg_load   = 1'b1;
        test_mode  = 1'b1;
        busy       = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        tpg_en    = 1'b1;
        test_mode = 1'b1;
        busy      = 1'b1;
        if (last_pat) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        test_mode = 1'b1;
        busy      = 1'b1;
        // Leave once the response still in flight is consumed on this edge.
        if (pipe_next == '0) state_next = S_EVAL;
      end
      S_EVAL: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort_hit) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misr        <= MISR_SEED;
      pattern_cnt <= '0;
      vpipe       <= '0;
      pass        <= 1'b0;
    end else if (abort_hit) begin
      vpipe <= '0;
      pass  <= 1'b0;
    end else begin
      vpipe <= pipe_next;
      if (state == S_LOAD) begin
        misr        <= MISR_SEED;
        pattern_cnt <= '0;
        pass        <= 1'b0;
      end else begin
        if (vpipe[CUT_LAT-1]) misr <= misr_next;
        if (state == S_RUN)   pattern_cnt <= pattern_cnt + 16'd1;
        if (state == S_EVAL)  pass <= (misr == GOLDEN_SIG);
      end
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: three instances (golden 00, golden 08, long latency)
// with a done-triggered scoreboard and inline timing checks.
module tb_bist_controller;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_ab = 1'b0, abort_ab = 1'b0;
  logic [7:0] resp_ab = 8'h00;
  logic       start_c = 1'b0, abort_c = 1'b0;
  logic [7:0] resp_c = 8'h00;

  logic        tpg_load_a, tpg_en_a, test_mode_a, busy_a, done_a, pass_a;
  logic [7:0]  sig_a;
  logic [15:0] cnt_a;
  logic [2:0]  st_a;
  logic        tpg_load_b, tpg_en_b, test_mode_b, busy_b, done_b, pass_b;
  logic [7:0]  sig_b;
  logic [15:0] cnt_b;
  logic [2:0]  st_b;
  logic        tpg_load_c, tpg_en_c, test_mode_c, busy_c, done_c, pass_c;
  logic [7:0]  sig_c;
  logic [15:0] cnt_c;
  logic [2:0]  st_c;

  bist_controller #(.WIDTH(8), .NUM_PATTERNS(4), .CUT_LAT(1), .MISR_SEED(8'h00),
                    .MISR_TAPS(8'hB8), .GOLDEN_SIG(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_ab), .abort(abort_ab),
    .tpg_load(tpg_load_a), .tpg_en(tpg_en_a), .test_mode(test_mode_a),
    .cut_resp(resp_ab), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pattern_cnt(cnt_a), .dbg_state(st_a));

  bist_controller #(.WIDTH(8), .NUM_PATTERNS(4), .CUT_LAT(1), .MISR_SEED(8'h00),
                    .MISR_TAPS(8'hB8), .GOLDEN_SIG(8'h08)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_ab), .abort(abort_ab),
    .tpg_load(tpg_load_b), .tpg_en(tpg_en_b), .test_mode(test_mode_b),
    .cut_resp(resp_ab), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pattern_cnt(cnt_b), .dbg_state(st_b));

  bist_controller #(.WIDTH(8), .NUM_PATTERNS(1), .CUT_LAT(3), .MISR_SEED(8'h00),
                    .MISR_TAPS(8'hB8), .GOLDEN_SIG(8'h00)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c),
    .tpg_load(tpg_load_c), .tpg_en(tpg_en_c), .test_mode(test_mode_c),
    .cut_resp(resp_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .pattern_cnt(cnt_c), .dbg_state(st_c));

  int n_checks = 0;
  int n_errors = 0;

  // Entries are {pass, signature, pattern_cnt}.
  logic [24:0] exp_a_q[$];
  logic [24:0] exp_b_q[$];
  logic [24:0] exp_c_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic no_entry(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: done rose with no expected entry queued", name);
  endtask

  // Scoreboard monitors: a rising done presents a result to compare.
  logic done_a_d = 1'b0, done_b_d = 1'b0, done_c_d = 1'b0;
  always @(negedge clk) begin
    done_a_d <= done_a;
    done_b_d <= done_b;
    done_c_d <= done_c;
    if (done_a && !done_a_d) begin
      if (exp_a_q.size() == 0) no_entry("a_result");
      else check("a_result", {7'd0, pass_a, sig_a, cnt_a}, {7'd0, exp_a_q.pop_front()});
    end
    if (done_b && !done_b_d) begin
      if (exp_b_q.size() == 0) no_entry("b_result");
      else check("b_result", {7'd0, pass_b, sig_b, cnt_b}, {7'd0, exp_b_q.pop_front()});
    end
    if (done_c && !done_c_d) begin
      if (exp_c_q.size() == 0) no_entry("c_result");
      else check("c_result", {7'd0, pass_c, sig_c, cnt_c}, {7'd0, exp_c_q.pop_front()});
    end
  end

  // One NUM_PATTERNS=4 session on instances a/b; response byte applied on edge resp_edge.
  task automatic session_ab(input string tag, input int resp_edge, input logic [7:0] resp_val,
                            input logic [31:0] exp_seq, input logic [7:0] exp_sig,
                            input logic exp_pass_a, input logic exp_pass_b);
    int en_cnt;
    en_cnt = 0;
    exp_a_q.push_back({exp_pass_a, exp_sig, 16'd4});
    exp_b_q.push_back({exp_pass_b, exp_sig, 16'd4});
    start_ab = 1'b1;
    @(posedge clk); #1;
    start_ab = 1'b0;
    check({tag, "_tpg_load"}, {31'd0, tpg_load_a}, 32'd1);
    en_cnt += int'(tpg_en_a);
    for (int e = 1; e <= 7; e++) begin
      resp_ab = (e == resp_edge) ? resp_val : 8'h00;
      @(posedge clk); #1;
      en_cnt += int'(tpg_en_a);
      if (e >= 3 && e <= 6) check({tag, "_sig_step"}, {24'd0, sig_a}, {24'd0, exp_seq[8*(6-e) +: 8]});
      check({tag, "_done"}, {31'd0, done_a}, {31'd0, (e == 7)});
    end
    resp_ab = 8'h00;
    check({tag, "_tpg_en_cycles"}, en_cnt, 32'd4);
    @(posedge clk); #1;
    check({tag, "_a_drained"}, exp_a_q.size(), 32'd0);
    check({tag, "_b_drained"}, exp_b_q.size(), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {26'd0, tpg_load_a, tpg_en_a, test_mode_a, busy_a, done_a, pass_a}, 32'd0);
    check("reset_sig_cnt", {8'd0, sig_a, cnt_a}, 32'd0);
    check("reset_state", {29'd0, st_a}, {29'd0, ST_IDLE});
    rst_n = 1'b1;
    @(posedge clk); #1;

    session_ab("clean", 0, 8'h00, 32'h00000000, 8'h00, 1'b1, 1'b0);

    // Abort from DONE clears done and pass.
    abort_ab = 1'b1;
    @(posedge clk); #1;
    abort_ab = 1'b0;
    check("abort_done_state", {29'd0, st_a}, {29'd0, ST_IDLE});
    check("abort_done_flags", {30'd0, done_a, pass_a}, 32'd0);

    session_ab("bit_e3", 3, 8'h01, 32'h01020408, 8'h08, 1'b0, 1'b1);
    session_ab("bit_e4", 4, 8'h01, 32'h00010204, 8'h04, 1'b0, 1'b0);

    // Abort together with start in the second RUN cycle.
    start_ab = 1'b1;
    @(posedge clk); #1;
    start_ab = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_run_pre", {29'd0, st_a}, {29'd0, ST_RUN});
    abort_ab = 1'b1;
    start_ab = 1'b1;
    @(posedge clk); #1;
    abort_ab = 1'b0;
    start_ab = 1'b0;
    check("abort_run_state", {29'd0, st_a}, {29'd0, ST_IDLE});
    check("abort_run_flags", {28'd0, tpg_en_a, busy_a, done_a, pass_a}, 32'd0);
    check("abort_run_cnt_hold", {16'd0, cnt_a}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("abort_stays_idle", {29'd0, st_a}, {29'd0, ST_IDLE});
    session_ab("after_abort", 0, 8'h00, 32'h00000000, 8'h00, 1'b1, 1'b0);

    // Latency sweep on instance c; a start during FLUSH must be ignored.
    exp_c_q.push_back({1'b0, 8'hFF, 16'd1});
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      resp_c  = (e == 5) ? 8'hFF : 8'h00;
      start_c = (e == 3);
      @(posedge clk); #1;
      check("lat_done", {31'd0, done_c}, {31'd0, (e >= 6)});
      check("lat_busy", {31'd0, busy_c}, {31'd0, (e <= 5)});
    end
    resp_c  = 8'h00;
    start_c = 1'b0;
    check("lat_drained", exp_c_q.size(), 32'd0);

    // Asynchronous reset while in FLUSH.
    resp_ab  = 8'h5A;
    start_ab = 1'b1;
    @(posedge clk); #1;
    start_ab = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("areset_pre_state", {29'd0, st_a}, {29'd0, ST_FLUSH});
    #2 rst_n = 1'b0;
    #1;
    check("areset_ctrl", {26'd0, tpg_load_a, tpg_en_a, test_mode_a, busy_a, done_a, pass_a}, 32'd0);
    check("areset_sig_cnt", {8'd0, sig_a, cnt_a}, 32'd0);
    check("areset_state", {29'd0, st_a}, {29'd0, ST_IDLE});
    resp_ab = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    session_ab("after_reset", 0, 8'h00, 32'h00000000, 8'h00, 1'b1, 1'b0);

    check("final_queues", exp_a_q.size() + exp_b_q.size() + exp_c_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
